// File: rtl/clock_period_meter_pkg.sv
`timescale 1ns/1ps
// Shared state encoding, defaults and sizing helper for the clock period meter
// and its asynchronous-input front end.
package clock_period_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_EDGE = 2'd1,
      ST_MEASURE   = 2'd2
   } meter_state_e;

   localparam int DEFAULT_TIMEOUT = 65535;
   localparam int DEFAULT_TOL     = 1;
   localparam int MIN_SYNC_STAGES = 2;

   // Bits needed to hold values 0..value-1, never less than one bit.
   function automatic int clog2_min1(input int value);
      int bits;
      bits = 0;
      while ((1 << bits) < value) begin
         bits++;
      end
      return (bits < 1) ? 1 : bits;
   endfunction

endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
`timescale 1ns/1ps
// Synchronizer chain plus one history flop for an asynchronous input; produces
// single-cycle rise/fall strobes in the clk domain.
module clock_period_meter_sync_edge_detect
   import clock_period_meter_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise,
   output logic fall
);

   localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic              hist_q;
   logic              hist_d;
   logic              level;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], async_in};
      hist_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~hist_q;
   assign fall  = ~level & hist_q;

endmodule

// File: rtl/clock_period_meter.sv
`timescale 1ns/1ps
// Measures period and high time of a slow, possibly asynchronous signal in clk
// cycles, with lock detection on period stability and a sticky edge timeout.
module clock_period_meter
   import clock_period_meter_pkg::*;
#(
   parameter int CNT_WIDTH   = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = DEFAULT_TIMEOUT,
   parameter int TOL         = DEFAULT_TOL,
   parameter int LOCK_COUNT  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 sig_in,
   output logic [CNT_WIDTH-1:0] period,
   output logic [CNT_WIDTH-1:0] high_time,
   output logic                 period_valid,
   output logic                 locked,
   output logic                 timeout
);

   localparam int MATCH_W = clog2_min1(LOCK_COUNT + 1);

   localparam logic        [CNT_WIDTH-1:0] TIMEOUT_V = CNT_WIDTH'(TIMEOUT);
   localparam logic        [MATCH_W-1:0]   LOCK_V    = MATCH_W'(LOCK_COUNT);
   localparam logic signed [CNT_WIDTH:0]   TOL_V     = (CNT_WIDTH + 1)'(TOL);
   localparam logic        [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   logic rise;
   logic fall;

   clock_period_meter_sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge_detect (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (sig_in),
      .rise     (rise),
      .fall     (fall)
   );

   meter_state_e         state_q,       state_d;
   logic [CNT_WIDTH-1:0] cnt_q,         cnt_d;
   logic [CNT_WIDTH-1:0] hi_cap_q,      hi_cap_d;
   logic                 fall_seen_q,   fall_seen_d;
   logic [CNT_WIDTH-1:0] prev_period_q, prev_period_d;
   logic                 have_prev_q,   have_prev_d;
   logic [MATCH_W-1:0]   match_cnt_q,   match_cnt_d;
   logic [CNT_WIDTH-1:0] period_q,      period_d;
   logic [CNT_WIDTH-1:0] high_time_q,   high_time_d;
   logic                 valid_q,       valid_d;
   logic                 locked_q,      locked_d;
   logic                 timeout_q,     timeout_d;

   logic [CNT_WIDTH-1:0]        cnt_inc;
   logic [MATCH_W-1:0]          match_inc;
   logic [MATCH_W-1:0]          match_next;
   logic signed [CNT_WIDTH:0]   diff;
   logic signed [CNT_WIDTH:0]   abs_diff;
   logic                        period_match;

   // Counter saturates at TIMEOUT so a dead input never wraps into a bogus period.
   always_comb begin
      cnt_inc      = (cnt_q == TIMEOUT_V) ? cnt_q : cnt_q + CNT_ONE;
      match_inc    = (match_cnt_q == LOCK_V) ? match_cnt_q : match_cnt_q + 1'b1;
      diff         = $signed({1'b0, cnt_q}) - $signed({1'b0, prev_period_q});
      abs_diff     = (diff < 0) ? -diff : diff;
      period_match = (abs_diff <= TOL_V);
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      hi_cap_d      = hi_cap_q;
      fall_seen_d   = fall_seen_q;
      prev_period_d = prev_period_q;
      have_prev_d   = have_prev_q;
      match_cnt_d   = match_cnt_q;
      period_d      = period_q;
      high_time_d   = high_time_q;
      valid_d       = 1'b0;
      locked_d      = locked_q;
      timeout_d     = timeout_q;
      match_next    = match_cnt_q;

      if (!enable) begin
         state_d     = ST_IDLE;
         cnt_d       = '0;
         fall_seen_d = 1'b0;
         have_prev_d = 1'b0;
         match_cnt_d = '0;
         locked_d    = 1'b0;
         timeout_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // The enabling cycle already counts toward the timeout window.
               state_d = ST_WAIT_EDGE;
               cnt_d   = CNT_ONE;
            end

            ST_WAIT_EDGE: begin
               if (rise) begin
                  state_d     = ST_MEASURE;
                  cnt_d       = CNT_ONE;
                  fall_seen_d = 1'b0;
                  have_prev_d = 1'b0;
               end else begin
                  cnt_d = cnt_inc;
                  if (cnt_q == TIMEOUT_V) begin
                     timeout_d = 1'b1;
                  end
               end
            end

            ST_MEASURE: begin
               if (rise) begin
                  if (have_prev_q) begin
                     match_next = period_match ? match_inc : '0;
                  end
                  cnt_d         = CNT_ONE;
                  period_d      = cnt_q;
                  high_time_d   = fall_seen_q ? hi_cap_q : cnt_q;
                  valid_d       = 1'b1;
                  timeout_d     = 1'b0;
                  fall_seen_d   = 1'b0;
                  prev_period_d = cnt_q;
                  have_prev_d   = 1'b1;
                  match_cnt_d   = match_next;
                  locked_d      = (match_next == LOCK_V);
               end else if (cnt_q == TIMEOUT_V) begin
                  state_d     = ST_WAIT_EDGE;
                  timeout_d   = 1'b1;
                  locked_d    = 1'b0;
                  match_cnt_d = '0;
                  have_prev_d = 1'b0;
               end else begin
                  cnt_d = cnt_inc;
                  if (fall) begin
                     hi_cap_d    = cnt_q;
                     fall_seen_d = 1'b1;
                  end
               end
            end

            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         hi_cap_q      <= '0;
         fall_seen_q   <= 1'b0;
         prev_period_q <= '0;
         have_prev_q   <= 1'b0;
         match_cnt_q   <= '0;
         period_q      <= '0;
         high_time_q   <= '0;
         valid_q       <= 1'b0;
         locked_q      <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         hi_cap_q      <= hi_cap_d;
         fall_seen_q   <= fall_seen_d;
         prev_period_q <= prev_period_d;
         have_prev_q   <= have_prev_d;
         match_cnt_q   <= match_cnt_d;
         period_q      <= period_d;
         high_time_q   <= high_time_d;
         valid_q       <= valid_d;
         locked_q      <= locked_d;
         timeout_q     <= timeout_d;
      end
   end

   assign period       = period_q;
   assign high_time    = high_time_q;
   assign period_valid = valid_q;
   assign locked       = locked_q;
   assign timeout      = timeout_q;

endmodule
